seg_status_decoder: RTL and testbench



---
 rtl/seg_status_pkg.sv | 27 ++
 rtl/seg_debouncer.sv | 41 ++++
 rtl/seg_status_decoder.sv | 104 ++++++++++
 tb/tb_seg_status_decoder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_status_pkg.sv
// Shared definitions for the seven-segment humidity status receive path:
// the four-code segment alphabet, the decoded status type and the handshake states.
package seg_status_pkg;

    localparam logic [7:0] SEG_ADEQUADA    = 8'h00;
    localparam logic [7:0] SEG_BAIXA_0     = 8'h3F;
    localparam logic [7:0] SEG_BAIXA_1     = 8'h06;
    localparam logic [7:0] SEG_BAIXA_0_E_1 = 8'h5B;

    typedef enum logic [1:0] {
        ST_ADEQUADA    = 2'b00,
        ST_BAIXA_0     = 2'b01,
        ST_BAIXA_1     = 2'b10,
        ST_BAIXA_0_E_1 = 2'b11
    } status_t;

    typedef enum logic {
        IDLE,
        PENDING
    } hs_state_t;

    // Any status other than "adequate" counts as an alarm condition.
    function automatic logic is_alarm(input status_t st);
        return st != ST_ADEQUADA;
    endfunction

endpackage

// File: rtl/seg_debouncer.sv
// Debounces the segment bus: a pattern qualifies once on its STABLE_CYCLES-th identical sample.
// Registered sampling, combinational qualify; no backpressure (observes the bus every cycle).
module seg_debouncer #(
    parameter int NBITS_SEG     = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic [NBITS_SEG-1:0] seg_in,
    output logic                 qualify,
    output logic [NBITS_SEG-1:0] qual_pat
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [NBITS_SEG-1:0] seg_q;
    logic [CW-1:0]        stab_cnt;
    logic                 same;

    assign same = (seg_in == seg_q);

    always_ff @(posedge clk_2) begin
        if (reset) begin
            seg_q    <= '0;
            stab_cnt <= '0;
        end else begin
            seg_q <= seg_in;
            if (!same) begin
                stab_cnt <= '0;
            end else if (stab_cnt != CW'(STABLE_CYCLES)) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

    // stab_cnt counts matches after the first sample of a run, so the
    // STABLE_CYCLES-th sample lands while it reads STABLE_CYCLES-2.
    assign qualify  = same && (stab_cnt == CW'(STABLE_CYCLES - 2));
    assign qual_pat = seg_q;

endmodule

// File: rtl/seg_status_decoder.sv
// Decodes debounced segment patterns into sensor status, counts alarms, flags bad codes.
// Commit STABLE_CYCLES-1 edges after first sample, valid one edge later; changes collapse while consumer stalls.
module seg_status_decoder
    import seg_status_pkg::*;
#(
    parameter int NBITS_SEG     = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int NBITS_CNT     = 8
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic [NBITS_SEG-1:0] seg_in,
    output logic [1:0]           status_out,
    output logic                 status_valid,
    input  logic                 status_ready,
    output logic                 invalid_flag,
    input  logic                 clear_invalid,
    output logic [NBITS_CNT-1:0] alarm_count
);

    logic                 qualify;
    logic [NBITS_SEG-1:0] qual_pat;
    logic                 dec_ok;
    status_t              dec_st;
    status_t              committed;
    hs_state_t            state;

    seg_debouncer #(
        .NBITS_SEG     (NBITS_SEG),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_debouncer (
        .clk_2    (clk_2),
        .reset    (reset),
        .seg_in   (seg_in),
        .qualify  (qualify),
        .qual_pat (qual_pat)
    );

    always_comb begin
        dec_ok = 1'b1;
        dec_st = ST_ADEQUADA;
        case (qual_pat)
            NBITS_SEG'(SEG_ADEQUADA):    dec_st = ST_ADEQUADA;
            NBITS_SEG'(SEG_BAIXA_0):     dec_st = ST_BAIXA_0;
            NBITS_SEG'(SEG_BAIXA_1):     dec_st = ST_BAIXA_1;
            NBITS_SEG'(SEG_BAIXA_0_E_1): dec_st = ST_BAIXA_0_E_1;
            default:                     dec_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            committed    <= ST_ADEQUADA;
            alarm_count  <= '0;
            invalid_flag <= 1'b0;
        end else begin
            if (qualify && dec_ok && (dec_st != committed)) begin
                committed <= dec_st;
                if (is_alarm(dec_st) && (alarm_count != '1)) begin
                    alarm_count <= alarm_count + 1'b1;
                end
            end
            // A new bad code outranks a simultaneous clear.
            if (qualify && !dec_ok) begin
                invalid_flag <= 1'b1;
            end else if (clear_invalid) begin
                invalid_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state        <= IDLE;
            status_out   <= 2'b00;
            status_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (committed != status_out) begin
                        status_out   <= committed;
                        status_valid <= 1'b1;
                        state        <= PENDING;
                    end
                end
                PENDING: begin
                    if (status_ready) begin
                        if (committed == status_out) begin
                            status_valid <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            status_out <= committed;
                        end
                    end
                end
                default: begin
                    status_valid <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_status_decoder.sv
// Bench for seg_status_decoder: run-length reference model plus directed literal checks and random stimulus.
module tb_seg_status_decoder;

    localparam int S = 4;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic [7:0] seg_in;
    logic       status_ready;
    logic       clear_invalid;

    logic [1:0] status_out_a, status_out_b;
    logic       status_valid_a, status_valid_b;
    logic       invalid_flag_a, invalid_flag_b;
    logic [7:0] alarm_count_a;
    logic [1:0] alarm_count_b;

    always #5 clk_2 = ~clk_2;

    seg_status_decoder #(.NBITS_SEG(8), .STABLE_CYCLES(S), .NBITS_CNT(8)) dut (
        .clk_2         (clk_2),
        .reset         (reset),
        .seg_in        (seg_in),
        .status_out    (status_out_a),
        .status_valid  (status_valid_a),
        .status_ready  (status_ready),
        .invalid_flag  (invalid_flag_a),
        .clear_invalid (clear_invalid),
        .alarm_count   (alarm_count_a)
    );

    seg_status_decoder #(.NBITS_SEG(8), .STABLE_CYCLES(S), .NBITS_CNT(2)) dut2 (
        .clk_2         (clk_2),
        .reset         (reset),
        .seg_in        (seg_in),
        .status_out    (status_out_b),
        .status_valid  (status_valid_b),
        .status_ready  (status_ready),
        .invalid_flag  (invalid_flag_b),
        .clear_invalid (clear_invalid),
        .alarm_count   (alarm_count_b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: run length of identical samples, delivered/committed status.
    logic [7:0] m_prev;
    int         m_run;
    int         m_comm;
    int         m_out;
    bit         m_valid;
    bit         m_flag;
    int         m_alarm8;
    int         m_alarm2;

    function automatic int code_of(input logic [7:0] p);
        case (p)
            8'h00:   return 0;
            8'h3F:   return 1;
            8'h06:   return 2;
            8'h5B:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_step();
        int c;
        bit qual;
        if (reset) begin
            m_prev = 8'h00; m_run = 1; m_comm = 0; m_out = 0;
            m_valid = 0; m_flag = 0; m_alarm8 = 0; m_alarm2 = 0;
        end else begin
            // Delivery sees the committed value from before this edge.
            if (!m_valid || status_ready) begin
                if (m_comm != m_out) begin
                    m_out = m_comm;
                    m_valid = 1;
                end else begin
                    m_valid = 0;
                end
            end
            if (seg_in == m_prev) begin
                if (m_run <= S) m_run++;
            end else begin
                m_run = 1;
            end
            m_prev = seg_in;
            qual = (m_run == S);
            c = code_of(seg_in);
            if (qual && c < 0) m_flag = 1;
            else if (clear_invalid) m_flag = 0;
            if (qual && c >= 0 && c != m_comm) begin
                m_comm = c;
                if (c != 0) begin
                    if (m_alarm8 < 255) m_alarm8++;
                    if (m_alarm2 < 3) m_alarm2++;
                end
            end
        end
    endtask

    always @(posedge clk_2) model_step();

    always @(negedge clk_2) begin
        if (chk_en) begin
            check("status_out",    status_out_a,   m_out);
            check("status_valid",  status_valid_a, m_valid);
            check("invalid_flag",  invalid_flag_a, m_flag);
            check("alarm_count",   alarm_count_a,  m_alarm8);
            check("status_out2",   status_out_b,   m_out);
            check("status_valid2", status_valid_b, m_valid);
            check("invalid_flag2", invalid_flag_b, m_flag);
            check("alarm_count2",  alarm_count_b,  m_alarm2);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_2);
    endtask

    initial begin
        logic [7:0] pat;
        reset = 1'b1; seg_in = 8'h00; status_ready = 1'b1; clear_invalid = 1'b0;
        step(1);
        chk_en = 1'b1;
        reset  = 1'b0;
        check("rst_valid", status_valid_a, 0);
        check("rst_out",   status_out_a,   0);
        check("rst_alarm", alarm_count_a,  0);
        check("rst_flag",  invalid_flag_a, 0);

        // Idle bus at the adequate code
        step(10);
        check("idle_valid", status_valid_a, 0);
        check("idle_out",   status_out_a,   0);
        check("idle_alarm", alarm_count_a,  0);

        // Alternate alarm/adequate five times: narrow counter saturates
        for (int i = 0; i < 5; i++) begin
            seg_in = 8'h3F; step(5);
            seg_in = 8'h00; step(5);
        end
        check("sat_alarm2", alarm_count_b, 3);
        check("sat_alarm8", alarm_count_a, 5);

        // Reset in the middle of activity
        seg_in = 8'h3F; step(4);
        reset = 1'b1; step(1);
        check("midrst_out",    status_out_a,   0);
        check("midrst_valid",  status_valid_a, 0);
        check("midrst_alarm",  alarm_count_a,  0);
        check("midrst_alarm2", alarm_count_b,  0);
        check("midrst_flag",   invalid_flag_a, 0);
        reset = 1'b0; seg_in = 8'h00; step(3);

        // First alarm: commit on 4th sample, valid one edge later, held until ready
        status_ready = 1'b0; seg_in = 8'h3F;
        step(4);
        check("lat_alarm", alarm_count_a, 1);
        check("lat_valid_lo", status_valid_a, 0);
        step(1);
        check("lat_valid_hi", status_valid_a, 1);
        check("lat_out", status_out_a, 1);
        step(3);
        check("hold_valid", status_valid_a, 1);
        status_ready = 1'b1; step(1);
        check("xfer_valid", status_valid_a, 0);

        // Glitch shorter than the qualify window
        seg_in = 8'h5B; step(3);
        seg_in = 8'h00; step(1);
        check("glitch_alarm", alarm_count_a, 1);
        check("glitch_valid", status_valid_a, 0);
        check("glitch_out",   status_out_a,   1);
        step(6);
        check("back_out",   status_out_a,   0);
        check("back_valid", status_valid_a, 0);

        // Non-alphabet code and clearing without requalification
        seg_in = 8'hFF; step(4);
        check("inv_set", invalid_flag_a, 1);
        check("inv_out", status_out_a,   0);
        step(2);
        clear_invalid = 1'b1; step(1);
        clear_invalid = 1'b0;
        check("inv_clr", invalid_flag_a, 0);
        step(5);
        check("inv_stay", invalid_flag_a, 0);

        // Commits collapse while the consumer stalls
        status_ready = 1'b0; seg_in = 8'h3F; step(6);
        check("pend_out",   status_out_a,   1);
        check("pend_valid", status_valid_a, 1);
        check("pend_alarm", alarm_count_a,  2);
        seg_in = 8'h06; step(5);
        seg_in = 8'h5B; step(5);
        check("coll_alarm", alarm_count_a,  4);
        check("coll_out",   status_out_a,   1);
        check("coll_valid", status_valid_a, 1);
        status_ready = 1'b1; step(1);
        check("b2b_out",   status_out_a,   3);
        check("b2b_valid", status_valid_a, 1);
        status_ready = 1'b0; step(1);
        check("b2b_hold", status_out_a, 3);
        status_ready = 1'b1; step(1);
        check("b2b_done", status_valid_a, 0);

        // Randomized traffic
        for (int it = 0; it < 1500; it++) begin
            int sel;
            int hold;
            sel  = $urandom_range(0, 9);
            hold = $urandom_range(1, 7);
            case (sel)
                0, 1:    pat = 8'h00;
                2, 7:    pat = 8'h3F;
                3, 8:    pat = 8'h06;
                4, 9:    pat = 8'h5B;
                5:       pat = 8'hFF;
                default: pat = 8'($urandom_range(0, 255));
            endcase
            seg_in = pat;
            for (int h = 0; h < hold; h++) begin
                status_ready  = ($urandom_range(0, 3) != 0);
                clear_invalid = ($urandom_range(0, 7) == 0);
                reset         = ($urandom_range(0, 299) == 0);
                step(1);
            end
        end
        reset = 1'b0; clear_invalid = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
